// File: rtl/rojobot_video_pkg.sv
// rtl/rojobot_video_pkg.sv - shared widths, pipeline latency and position FSM encoding for the video fetch path
package rojobot_video_pkg;

    localparam int COLOR_W       = 12;
    localparam int PIX_COORD_W   = 12;
    localparam int FETCH_LATENCY = 3;

    typedef enum logic {
        POS_IDLE    = 1'b0,
        POS_PENDING = 1'b1
    } pos_state_t;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - resettable fixed-depth shift register for sync/flag alignment
module sync_delay #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/image_fetch.sv
// rtl/image_fetch.sv - DTG-coordinate to image-RAM fetch with aligned pixel/sync outputs; IMAGE_FETCH_TRANSPARENCY_EN enables colour keying
module image_fetch
    import rojobot_video_pkg::*;
#(
    parameter int                 DATA_WIDTH  = 12,
    parameter int                 ADDR_WIDTH  = 15,
    parameter int                 IMG_W       = 128,
    parameter int                 IMG_H       = 256,
    parameter int                 SCALE_SHIFT = 0,
    parameter logic [COLOR_W-1:0] BG_COLOR    = 12'h000,
    parameter logic [COLOR_W-1:0] KEY_COLOR   = 12'hF0F
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   video_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [PIX_COORD_W-1:0] pixel_row,
    input  logic [PIX_COORD_W-1:0] pixel_column,
    input  logic [PIX_COORD_W-1:0] pos_x,
    input  logic [PIX_COORD_W-1:0] pos_y,
    input  logic                   pos_load,
    output logic                   pos_ack,
    output logic [ADDR_WIDTH-1:0]  read_addr,
    input  logic [DATA_WIDTH-1:0]  q,
    output logic [COLOR_W-1:0]     pixel_out,
    output logic                   in_image,
    output logic                   video_on_out,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    localparam int RW = PIX_COORD_W + 1;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = ADDR_WIDTH - XW;
    localparam logic [RW-1:0] SPAN_X = RW'(IMG_W << SCALE_SHIFT);
    localparam logic [RW-1:0] SPAN_Y = RW'(IMG_H << SCALE_SHIFT);
`ifdef IMAGE_FETCH_TRANSPARENCY_EN
    localparam bit KEYING = 1'b1;
`else
    localparam bit KEYING = 1'b0;
`endif

    pos_state_t             state, state_next;
    logic                   go_live;
    logic                   vsync_d;
    logic                   vsync_rise;
    logic [PIX_COORD_W-1:0] act_x, act_y, pend_x, pend_y;

    logic [RW-1:0]          rel_x, rel_y;
    logic [XW-1:0]          tex_x;
    logic [YW-1:0]          tex_y;
    logic                   hit;

    logic                   von_s2, hs_s2, vs_s2, hit_s2;
    logic                   keyed, show;

    assign vsync_rise = vsync_in & ~vsync_d;

    always_comb begin
        state_next = state;
        go_live    = 1'b0;
        case (state)
            POS_IDLE: begin
                if (pos_load) state_next = POS_PENDING;
            end
            POS_PENDING: begin
                // A load landing on the edge is kept for the following frame.
                if (vsync_rise) begin
                    go_live    = 1'b1;
                    state_next = pos_load ? POS_PENDING : POS_IDLE;
                end
            end
            default: state_next = POS_IDLE;
        endcase
    end

    // Unsigned coordinates widened by one bit so left/above-the-image shows up as a set sign bit.
    assign rel_x = {1'b0, pixel_column} - {1'b0, act_x};
    assign rel_y = {1'b0, pixel_row}    - {1'b0, act_y};
    assign hit   = ~rel_x[RW-1] & (rel_x < SPAN_X) & ~rel_y[RW-1] & (rel_y < SPAN_Y);
    assign tex_x = XW'(rel_x >> SCALE_SHIFT);
    assign tex_y = YW'(rel_y >> SCALE_SHIFT);

    sync_delay #(
        .WIDTH (4),
        .DEPTH (FETCH_LATENCY - 1)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({video_on, hsync_in, vsync_in, hit}),
        .q     ({von_s2, hs_s2, vs_s2, hit_s2})
    );

    assign keyed = KEYING && (COLOR_W'(q) == KEY_COLOR);
    assign show  = hit_s2 & von_s2 & ~keyed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= POS_IDLE;
            vsync_d      <= 1'b0;
            pos_ack      <= 1'b0;
            pend_x       <= '0;
            pend_y       <= '0;
            act_x        <= '0;
            act_y        <= '0;
            read_addr    <= '0;
            pixel_out    <= BG_COLOR;
            in_image     <= 1'b0;
            video_on_out <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            state   <= state_next;
            vsync_d <= vsync_in;
            pos_ack <= go_live;
            if (pos_load) begin
                pend_x <= pos_x;
                pend_y <= pos_y;
            end
            if (go_live) begin
                act_x <= pend_x;
                act_y <= pend_y;
            end
            if (hit) read_addr <= {tex_y, tex_x};
            pixel_out    <= show ? COLOR_W'(q) : BG_COLOR;
            in_image     <= show;
            video_on_out <= von_s2;
            hsync_out    <= hs_s2;
            vsync_out    <= vs_s2;
        end
    end

endmodule

// File: tb/tb_image_fetch.sv
// tb/tb_image_fetch.sv - self-checking bench for image_fetch (scale 1x and 2x instances, table + random vs reference model)
`timescale 1ns/1ps
module tb_image_fetch;

    localparam logic [11:0] BG = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on, hsync_in, vsync_in, pos_load;
    logic [11:0] pixel_row, pixel_column, pos_x, pos_y;
    logic        pos_load1;
    logic [11:0] pos_zero;

    logic        ack0, ack1, in0, in1, von0, von1, hs0, hs1, vs0, vs1;
    logic [14:0] ra0, ra1;
    logic [11:0] q0, q1, pix0, pix1;

    int tests = 0;
    int failed = 0;
    int ack_seen = 0;

    always #5 clk = ~clk;

    // RAM preloaded with texel = addr[11:0], one-cycle synchronous read
    always @(posedge clk) begin
        q0 <= ra0[11:0];
        q1 <= ra1[11:0];
    end

    image_fetch #(.SCALE_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_row(pixel_row), .pixel_column(pixel_column), .pos_x(pos_x), .pos_y(pos_y),
        .pos_load(pos_load), .pos_ack(ack0), .read_addr(ra0), .q(q0), .pixel_out(pix0),
        .in_image(in0), .video_on_out(von0), .hsync_out(hs0), .vsync_out(vs0)
    );

    image_fetch #(.SCALE_SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_row(pixel_row), .pixel_column(pixel_column), .pos_x(pos_zero), .pos_y(pos_zero),
        .pos_load(pos_load1), .pos_ack(ack1), .read_addr(ra1), .q(q1), .pixel_out(pix1),
        .in_image(in1), .video_on_out(von1), .hsync_out(hs1), .vsync_out(vs1)
    );

    typedef struct {
        int          addr0, addr1;
        logic [11:0] pix0, pix1;
        bit          in0, in1, von, hs, vs;
    } exp_t;

    typedef struct {
        int row, col, addr0;
        bit hit0;
        int addr1;
        bit hit1;
    } vec_t;

    int   m_act_x, m_act_y, m_pend_x, m_pend_y, m_last0, m_last1;
    bit   m_pending, m_prev_vs;
    exp_t hist[$];
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int ss, input int ax, input int ay, output int addr);
        int rx = int'(pixel_column) - ax;
        int ry = int'(pixel_row) - ay;
        bit h  = rx >= 0 && rx < 128 * (1 << ss) && ry >= 0 && ry < 256 * (1 << ss);
        addr = h ? (ry / (1 << ss)) * 128 + rx / (1 << ss) : 0;
        return h;
    endfunction

    function automatic void pix_model(input bit hit, input int addr, output logic [11:0] pix, output bit inimg);
        logic [11:0] tex = 12'(addr % 4096);
        inimg = hit && video_on;
`ifdef IMAGE_FETCH_TRANSPARENCY_EN
        if (tex == 12'hF0F) inimg = 1'b0;
`endif
        pix = inimg ? tex : BG;
    endfunction

    task automatic model_reset();
        exp_t r;
        r = '{default: 0};
        r.pix0 = BG;
        r.pix1 = BG;
        m_act_x = 0; m_act_y = 0; m_pend_x = 0; m_pend_y = 0;
        m_pending = 0; m_prev_vs = 0; m_last0 = 0; m_last1 = 0;
        hist.delete();
        hist.push_back(r);
        hist.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read_addr"}, 32'(ra0), 0);
        chk({tag, "_pixel_out"}, 32'(pix0), 32'(BG));
        chk({tag, "_in_image"}, 32'(in0), 0);
        chk({tag, "_pos_ack"}, 32'(ack0), 0);
        chk({tag, "_syncs"}, {29'd0, von0, hs0, vs0}, 0);
        chk({tag, "_pixel_out_s1"}, 32'(pix1), 32'(BG));
    endtask

    task automatic tick();
        exp_t e;
        int   a0, a1;
        bit   h0, h1, rise, ack;
        h0 = model_hit(0, m_act_x, m_act_y, a0);
        h1 = model_hit(1, 0, 0, a1);
        if (h0) m_last0 = a0;
        if (h1) m_last1 = a1;
        e.addr0 = m_last0;
        e.addr1 = m_last1;
        pix_model(h0, a0, e.pix0, e.in0);
        pix_model(h1, a1, e.pix1, e.in1);
        e.von = video_on; e.hs = hsync_in; e.vs = vsync_in;
        rise = vsync_in && !m_prev_vs;
        ack  = m_pending && rise;
        if (ack) begin m_act_x = m_pend_x; m_act_y = m_pend_y; end
        if (pos_load) begin
            m_pend_x = int'(pos_x); m_pend_y = int'(pos_y); m_pending = 1;
        end else if (ack) begin
            m_pending = 0;
        end
        m_prev_vs = vsync_in;
        hist.push_back(e);
        @(posedge clk);
        #1;
        if (ack0 === 1'b1) ack_seen++;
        chk("read_addr", 32'(ra0), e.addr0);
        chk("read_addr_s1", 32'(ra1), e.addr1);
        chk("pos_ack", 32'(ack0), 32'(ack));
        e = hist[hist.size() - 3];
        chk("pixel_out", 32'(pix0), 32'(e.pix0));
        chk("in_image", 32'(in0), 32'(e.in0));
        chk("pixel_out_s1", 32'(pix1), 32'(e.pix1));
        chk("in_image_s1", 32'(in1), 32'(e.in1));
        chk("delayed_syncs", {29'd0, von0, hs0, vs0}, {29'd0, e.von, e.hs, e.vs});
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic load_pos(input int x, input int y);
        pos_x = 12'(x); pos_y = 12'(y); pos_load = 1'b1;
        tick();
        pos_load = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1; tick(); tick();
        vsync_in = 1'b0; tick();
    endtask

    task automatic probe(input string tag, input int row, input int col, input int exp_addr, input bit exp_in, input logic [11:0] exp_pix);
        pixel_row = 12'(row); pixel_column = 12'(col);
        tick();
        chk({tag, "_addr"}, 32'(ra0), exp_addr);
        tick(); tick();
        chk({tag, "_in"}, 32'(in0), 32'(exp_in));
        chk({tag, "_pix"}, 32'(pix0), 32'(exp_pix));
    endtask

    initial begin
        vt = '{
            '{50, 100, 0, 1, 3250, 1},
            '{50,  99, 0, 0, 3249, 1},
            '{50, 227, 127, 1, 3313, 1},
            '{50, 228, 127, 0, 3314, 1},
            '{0,    0, 127, 0, 0, 1},
            '{0,    1, 127, 0, 0, 1},
            '{0,    2, 127, 0, 1, 1},
            '{0,    3, 127, 0, 1, 1},
            '{2,    0, 127, 0, 128, 1},
            '{305, 100, 32640, 1, 19506, 1},
            '{306, 100, 32640, 0, 19634, 1},
            '{511, 255, 32640, 0, 32767, 1},
            '{512,   0, 32640, 0, 32767, 0}
        };
        reset = 1'b1;
        video_on = 0; hsync_in = 0; vsync_in = 0; pos_load = 0; pos_load1 = 0;
        pixel_row = 0; pixel_column = 0; pos_x = 0; pos_y = 0; pos_zero = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        model_reset();
        video_on = 1'b1;
        pixel_row = 600; pixel_column = 600;
        repeat (3) tick();

        // Table: image at (100,50) on the 1x instance, 2x instance fixed at (0,0)
        load_pos(100, 50);
        vsync_pulse();
        for (int i = 0; i < 13; i++) begin
            pixel_row = 12'(vt[i].row); pixel_column = 12'(vt[i].col);
            tick();
            chk("tbl_addr0", 32'(ra0), vt[i].addr0);
            chk("tbl_addr1", 32'(ra1), vt[i].addr1);
            tick(); tick();
            chk("tbl_in0", 32'(in0), 32'(vt[i].hit0));
            chk("tbl_pix0", 32'(pix0), vt[i].hit0 ? vt[i].addr0 % 4096 : 32'(BG));
            chk("tbl_in1", 32'(in1), 32'(vt[i].hit1));
            chk("tbl_pix1", 32'(pix1), vt[i].hit1 ? vt[i].addr1 % 4096 : 32'(BG));
        end

        // Two loads before one vsync: single ack, last load wins
        ack_seen = 0;
        load_pos(300, 200);
        repeat (4) tick();
        load_pos(310, 210);
        repeat (4) tick();
        vsync_pulse();
        repeat (3) tick();
        chk("single_ack", ack_seen, 1);
        probe("latest_pos", 210, 310, 0, 1'b1, 12'h000);

        // Load on the vsync edge: old pending goes live, new one waits a frame
        load_pos(10, 10);
        pos_x = 20; pos_y = 30; pos_load = 1'b1; vsync_in = 1'b1;
        tick();
        pos_load = 1'b0;
        tick();
        probe("edge_old", 10, 10, 0, 1'b1, 12'h000);
        vsync_in = 1'b0; tick();
        vsync_pulse();
        probe("edge_new", 31, 21, 129, 1'b1, 12'h081);

        // Right-edge clipping without wrap, then asynchronous reset mid-line
        load_pos(4000, 0);
        vsync_pulse();
        probe("clip_last", 0, 4095, 95, 1'b1, 12'h05F);
        probe("clip_nowrap", 0, 0, 95, 1'b0, BG);
        pixel_column = 4050;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1 check_reset_outputs("midline_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (4) tick();

        // Colour key texel (addr 3855 -> 12'hF0F)
`ifdef IMAGE_FETCH_TRANSPARENCY_EN
        probe("key", 30, 15, 3855, 1'b0, BG);
`else
        probe("key", 30, 15, 3855, 1'b1, 12'hF0F);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            video_on = ($urandom_range(0, 3) != 0);
            hsync_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) vsync_in = ~vsync_in;
            pixel_row    = 12'($urandom_range(0, 700));
            pixel_column = 12'($urandom_range(0, 800));
            if ($urandom_range(0, 7) == 0) pixel_column = 12'($urandom_range(3900, 4095));
            pos_load = ($urandom_range(0, 31) == 0);
            if (pos_load) begin
                pos_x = 12'($urandom_range(0, 500));
                pos_y = 12'($urandom_range(0, 400));
                if ($urandom_range(0, 3) == 0) pos_x = 12'($urandom_range(3950, 4095));
            end
            tick();
        end
        pos_load = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
